// File: rtl/alu_pkg.sv
// alu_pkg: ALU operation encoding shared by the ALU decoder and the execute stage.
//   alu_ctrl_t      3-bit operation code
//   ALU_*           legal operation codes (100, 110, 111 are unsupported)
//   alu_ctrl_legal  returns 1 when a code names a supported operation
package alu_pkg;

  typedef logic [2:0] alu_ctrl_t;

  localparam alu_ctrl_t ALU_ADD = 3'b000;
  localparam alu_ctrl_t ALU_SUB = 3'b001;
  localparam alu_ctrl_t ALU_AND = 3'b010;
  localparam alu_ctrl_t ALU_OR  = 3'b011;
  localparam alu_ctrl_t ALU_SLT = 3'b101;

  function automatic logic alu_ctrl_legal(alu_ctrl_t ctrl);
    return (ctrl == ALU_ADD) || (ctrl == ALU_SUB) || (ctrl == ALU_AND) ||
           (ctrl == ALU_OR)  || (ctrl == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU datapath.
//   ctrl_i      operation code (alu_ctrl_t)
//   a_i, b_i    operands
//   result_o    operation result (0 for unsupported codes)
//   zero_o      result_o == 0
//   overflow_o  signed overflow, ADD/SUB only
//   illegal_o   ctrl_i is not a supported operation
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  alu_ctrl_t        ctrl_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             overflow_o,
  output logic             illegal_o
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             lt_signed;
  logic             a_msb;
  logic             b_msb;

  assign sum       = a_i + b_i;
  assign diff      = a_i - b_i;
  assign a_msb     = a_i[WIDTH-1];
  assign b_msb     = b_i[WIDTH-1];
  // True signed compare, so SLT stays correct when a-b overflows.
  assign lt_signed = $signed(a_i) < $signed(b_i);

  always_comb begin
    result_o   = '0;
    overflow_o = 1'b0;
    illegal_o  = !alu_ctrl_legal(ctrl_i);
    case (ctrl_i)
      ALU_ADD: begin
        result_o   = sum;
        overflow_o = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);
      end
      ALU_SUB: begin
        result_o   = diff;
        overflow_o = (a_msb != b_msb) && (diff[WIDTH-1] != a_msb);
      end
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_SLT: result_o = {{(WIDTH-1){1'b0}}, lt_signed};
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: two-stage registered ALU with valid/ready on both sides.
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   operand beat handshake (alu_control, src_a, src_b)
//   out_valid / out_ready result beat handshake (result, zero, overflow, illegal)
// S1 holds the accepted operands, S2 holds the computed result. Beats leave in
// acceptance order; S2 is held stable while stalled.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  logic             s1_valid_q;
  alu_ctrl_t        s1_ctrl_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;

  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_result_q;
  logic             s2_zero_q;
  logic             s2_overflow_q;
  logic             s2_illegal_q;

  logic             s1_load;
  logic             s2_load;

  logic [WIDTH-1:0] core_result;
  logic             core_zero;
  logic             core_overflow;
  logic             core_illegal;

  // S2 frees up either when empty or when its beat leaves this cycle.
  assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s2_load;
  assign s1_load  = in_valid && in_ready;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_alu_core (
    .ctrl_i     (s1_ctrl_q),
    .a_i        (s1_a_q),
    .b_i        (s1_b_q),
    .result_o   (core_result),
    .zero_o     (core_zero),
    .overflow_o (core_overflow),
    .illegal_o  (core_illegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_ctrl_q  <= ALU_ADD;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_q <= 1'b1;
        s1_ctrl_q  <= alu_control;
        s1_a_q     <= src_a;
        s1_b_q     <= src_b;
      end else if (s2_load) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_q    <= 1'b0;
      s2_result_q   <= '0;
      s2_zero_q     <= 1'b0;
      s2_overflow_q <= 1'b0;
      s2_illegal_q  <= 1'b0;
    end else begin
      if (s2_load) begin
        s2_valid_q    <= 1'b1;
        s2_result_q   <= core_result;
        s2_zero_q     <= core_zero;
        s2_overflow_q <= core_overflow;
        s2_illegal_q  <= core_illegal;
      end else if (out_ready) begin
        s2_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = s2_result_q;
  assign zero      = s2_zero_q;
  assign overflow  = s2_overflow_q;
  assign illegal   = s2_illegal_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
module tb_alu_exec_stage;

  localparam int unsigned W = 32;
  localparam longint MaxS = 64'sd2147483647;
  localparam longint MinS = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   alu_control;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         overflow;
  logic         illegal;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        o;
    logic        il;
  } vec_t;

  always #5 clk = ~clk;

  alu_exec_stage #(
    .WIDTH(W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .overflow    (overflow),
    .illegal     (illegal)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: wide signed arithmetic, range test for overflow.
  function automatic vec_t model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    vec_t   v;
    longint sa;
    longint sb;
    longint s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    v.ctrl = c;
    v.a    = a;
    v.b    = b;
    v.res  = 32'h0;
    v.o    = 1'b0;
    v.il   = 1'b0;
    case (c)
      3'b000: begin
        s = sa + sb;
        v.res = s[31:0];
        v.o = (s > MaxS) || (s < MinS);
      end
      3'b001: begin
        s = sa - sb;
        v.res = s[31:0];
        v.o = (s > MaxS) || (s < MinS);
      end
      3'b010: v.res = a & b;
      3'b011: v.res = a | b;
      3'b101: v.res = (sa < sb) ? 32'h1 : 32'h0;
      default: v.il = 1'b1;
    endcase
    v.z = (v.res == 32'h0);
    return v;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 4))
      0: return 32'h7FFFFFFF;
      1: return 32'h80000000;
      2: return 32'($urandom_range(0, 7));
      3: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic send_beat(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    int n;
    alu_control = c;
    src_a       = a;
    src_b       = b;
    in_valid    = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    check1("in_ready_wait", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check1("out_valid_wait", out_valid, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[13];
    vec_t        exp_q[$];
    vec_t        e;
    logic [31:0] got[$];
    int          got_cyc[$];
    int          lat;
    int          idx;
    int          sent;
    int          recv;
    int          cyc;
    logic        take;
    logic        stale;

    reset       = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    alu_control = 3'b000;
    src_a       = '0;
    src_b       = '0;

    tbl[0]  = '{3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{3'b001, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{3'b101, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{3'b101, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{3'b110, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{3'b011, 32'h0F0F0000, 32'h0000F0F0, 32'h0F0FF0F0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{3'b001, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{3'b101, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{3'b100, 32'h12345678, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{3'b111, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{3'b001, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check1("rst_out_valid", out_valid, 1'b0);
    check32("rst_result", result, 32'h0);
    check1("rst_zero", zero, 1'b0);
    check1("rst_overflow", overflow, 1'b0);
    check1("rst_illegal", illegal, 1'b0);
    check1("rst_in_ready", in_ready, 1'b1);
    reset = 1'b0;
    step();

    // Directed table, one beat at a time
    out_ready = 1'b1;
    foreach (tbl[i]) begin
      send_beat(tbl[i].ctrl, tbl[i].a, tbl[i].b);
      wait_out(lat);
      check32($sformatf("tbl%0d_latency", i), 32'(lat), 32'd1);
      check32($sformatf("tbl%0d_result", i), result, tbl[i].res);
      check1($sformatf("tbl%0d_zero", i), zero, tbl[i].z);
      check1($sformatf("tbl%0d_overflow", i), overflow, tbl[i].o);
      check1($sformatf("tbl%0d_illegal", i), illegal, tbl[i].il);
      step();
      check1($sformatf("tbl%0d_drained", i), out_valid, 1'b0);
    end

    // Back-to-back SUB then SLT
    in_valid = 1'b1; alu_control = 3'b001; src_a = 32'd5; src_b = 32'd5;
    step();
    alu_control = 3'b101; src_a = 32'hFFFFFFFF; src_b = 32'd1;
    step();
    in_valid = 1'b0;
    check1("b2b_valid0", out_valid, 1'b1);
    check32("b2b_result0", result, 32'h0);
    check1("b2b_zero0", zero, 1'b1);
    step();
    check1("b2b_valid1", out_valid, 1'b1);
    check32("b2b_result1", result, 32'h1);
    check1("b2b_zero1", zero, 1'b0);
    step();
    check1("b2b_empty", out_valid, 1'b0);

    // Backpressure: four ADD beats, out_ready low
    out_ready = 1'b0;
    in_valid = 1'b1; alu_control = 3'b000; src_a = 32'd1; src_b = 32'd1;
    check1("bp_in_ready0", in_ready, 1'b1);
    step();
    src_a = 32'd2; src_b = 32'd2;
    check1("bp_in_ready1", in_ready, 1'b1);
    step();
    src_a = 32'd3; src_b = 32'd3;
    check1("bp_in_ready2", in_ready, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check1("bp_stall_valid", out_valid, 1'b1);
      check32("bp_stall_result", result, 32'd2);
      check1("bp_stall_in_ready", in_ready, 1'b0);
      step();
    end
    out_ready = 1'b1;
    #1;
    idx = 2;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) begin
        got.push_back(result);
        got_cyc.push_back(c);
      end
      take = in_valid && in_ready;
      step();
      if (take) idx++;
      if (idx < 4) begin
        src_a = 32'(idx + 1);
        src_b = 32'(idx + 1);
      end else begin
        in_valid = 1'b0;
      end
    end
    check32("bp_count", 32'(got.size()), 32'd4);
    for (int k = 0; k < got.size() && k < 4; k++) begin
      check32($sformatf("bp_order%0d", k), got[k], 32'(2 * (k + 1)));
      check32($sformatf("bp_cycle%0d", k), 32'(got_cyc[k]), 32'(k));
    end

    // Reset mid-stall with two beats in flight
    out_ready = 1'b0;
    in_valid = 1'b1; alu_control = 3'b000; src_a = 32'd10; src_b = 32'd10;
    step();
    src_a = 32'd20; src_b = 32'd20;
    step();
    in_valid = 1'b0;
    step();
    check1("mid_stall_valid", out_valid, 1'b1);
    check1("mid_stall_in_ready", in_ready, 1'b0);
    reset = 1'b1;
    #1;
    check1("arst_out_valid", out_valid, 1'b0);
    check32("arst_result", result, 32'h0);
    check1("arst_zero", zero, 1'b0);
    check1("arst_overflow", overflow, 1'b0);
    check1("arst_illegal", illegal, 1'b0);
    check1("arst_in_ready", in_ready, 1'b1);
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    stale = 1'b0;
    repeat (6) begin
      step();
      if (out_valid) stale = 1'b1;
    end
    check1("arst_no_stale", stale, 1'b0);

    // Random streaming against the reference model
    sent = 0;
    recv = 0;
    cyc  = 0;
    while ((sent < 100 || exp_q.size() > 0) && cyc < 3000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (sent < 100 && $urandom_range(0, 3) != 0) begin
        in_valid    = 1'b1;
        alu_control = 3'($urandom_range(0, 7));
        src_a       = pick_operand();
        src_b       = pick_operand();
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check32($sformatf("rnd%0d_result", recv), result, e.res);
          check1($sformatf("rnd%0d_zero", recv), zero, e.z);
          check1($sformatf("rnd%0d_overflow", recv), overflow, e.o);
          check1($sformatf("rnd%0d_illegal", recv), illegal, e.il);
          recv++;
        end else begin
          check1("rnd_unexpected_beat", out_valid, 1'b0);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(alu_control, src_a, src_b));
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    check32("rnd_received", 32'(recv), 32'd100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute-side consumer of the 3-bit alu_control code produced by the ALU decoder.
- Accepts operands plus alu_control through a valid/ready handshake.
- Computes in a registered 2-stage pipeline and returns the result, zero, overflow and illegal-code flags through a second valid/ready handshake.
- Sits between decode/operand-fetch and writeback; the first step toward the pipelined core.

Parameters:
- WIDTH, 32, datapath width in bits (≥ 2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand/control beat valid.
- in_ready  output  1  stage can accept a beat this cycle.
- alu_control  input  3  operation code from the ALU decoder.
- src_a  input  WIDTH  operand A.
- src_b  input  WIDTH  operand B.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- result  output  WIDTH  operation result.
- zero  output  1  result == 0.
- overflow  output  1  signed overflow (add/sub only).
- illegal  output  1  alu_control was an unsupported code.

Behaviour:
- Encodings:
  - 000 ADD: a+b mod 2^WIDTH.
  - 001 SUB: a−b mod 2^WIDTH.
  - 010 AND: a&b.
  - 011 OR: a|b.
  - 101 SLT: result = 1 if signed(a) < signed(b), else 0; zero-extended.
  - 100, 110, 111: result = 0, illegal = 1, overflow = 0.
- overflow:
  - ADD: a and b have the same sign and the result sign differs.
  - SUB: a and b have different signs and the result sign differs from a.
  - All other ops: 0.
- SLT uses the true signed compare, not the sign of the subtraction; it is correct across overflow.
- zero is derived from the final result for every op, including illegal codes (zero = 1 in that case).
- Pipeline:
  - S1 registers {alu_control, src_a, src_b}.
  - S2 registers {result, zero, overflow, illegal} computed from S1.
  - Each stage has its own valid bit.
- Transfers: input on in_valid & in_ready; output on out_valid & out_ready.
- Advance rules:
  - S2 loads when S1 valid and (!S2 valid or out_ready).
  - S1 loads when in_valid and in_ready.
  - in_ready = !S1 valid or S1 advancing this cycle. Combinational from out_ready; no combinational path from in_valid.
- Latency: 2 cycles from input handshake to out_valid, with no stall.
- Throughput: 1 beat/cycle while out_ready is held high.
- Backpressure:
  - While out_valid & !out_ready: result, zero, overflow and illegal are held stable.
  - S1 holds its beat; in_ready = 0 once S1 is occupied.
  - No beat is lost or duplicated.
- Simultaneous events: the output handshake and a new S1→S2 move in the same cycle are allowed; S2 is overwritten with the next beat.
- Out-of-order and reordering: none; beats exit in acceptance order.
- Reset, asserted at any time, including mid-stall:
  - Both valid bits clear immediately; in-flight beats are dropped.
  - Outputs: out_valid = 0, result = 0, zero = 0, overflow = 0, illegal = 0.
  - in_ready = 1 (combinationally follows the cleared S1 valid).
- Data registers are reset as well, so outputs are deterministic.
- Inputs are sampled only on a handshake; src/control values while in_valid = 0 are don't-care.

Decomposition:
- Package alu_pkg:
  - alu_ctrl_t (3-bit) with constants ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR = 3'b011, ALU_SLT = 3'b101.
  - Shared with the ALU decoder so both ends agree on the encoding.
- One natural combinational sub-module, alu_core:
  - Inputs: ctrl, a, b.
  - Outputs: result, zero, overflow, illegal.
  - Instantiated between S1 and S2; keeps the pipeline/handshake logic separate from the arithmetic.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001, out_ready = 1 → after 2 cycles result = 0x80000000, overflow = 1, zero = 0, illegal = 0.
- SUB 5−5, then SLT a = 0xFFFFFFFF (−1), b = 1, back-to-back:
  - cycle N+2: result = 0, zero = 1.
  - cycle N+3: result = 1.
  - SLT a = 1, b = 0xFFFFFFFF → result = 0.
- Code 110 with a = 0xF0F0F0F0, b = 0x0F0F0F0F → result = 0, illegal = 1, zero = 1; the next AND beat (0xF0F0F0F0 & 0xFF00FF00) → result = 0xF000F000, illegal = 0.
- Backpressure:
  - Send 4 beats (ADD 1+1, 2+2, 3+3, 4+4) with out_ready = 0 → in_ready drops after 2 accepted; out_valid = 1 with result = 2 held stable.
  - Release out_ready → results 2, 4, 6, 8 in order, one per cycle, no loss or duplication.
- Reset mid-stall: with 2 beats in flight and out_ready = 0, assert reset for 1 cycle → out_valid = 0 and all outputs 0 immediately; in_ready = 1; no stale beat appears after release.
- Streaming: 100 random beats with random out_ready → scoreboard against a reference model; every result, zero, overflow and illegal matches in order.
